// File: rtl/div_unit_pkg.sv
// Shared types and constants for the EX-stage iterative divider.
// Holds the FSM state encoding and the default datapath width.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_unit_iter.sv
// div_iter: one combinational restoring-division step.
// Ports: rem_i/quo_i/divisor_i in, next rem_o/quo_o out.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;

  // The remainder stays below the divisor, so the
  // shifted value always fits in WIDTH+1 bits.
  assign rem_sh = {rem_i, quo_i[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, divisor_i};

  always_comb begin
    if (!trial[WIDTH]) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle DIV/DIVU for the HI/LO path.
// Ports: start/signed/operands/flush in; stall, done, q, r out.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH);

  div_state_e     state_q;
  logic [CW-1:0]  cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic           qneg_q;
  logic           rneg_q;
  logic           done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remd_q;

  logic           dvd_neg;
  logic           dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] quo_d;
  logic           last;

  assign dvd_neg = signed_i & dividend_i[WIDTH-1];
  assign dvs_neg = signed_i & divisor_i[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_mag = dvs_neg ? -divisor_i : divisor_i;
  assign last    = (cnt_q == CW'(WIDTH - 1));

  div_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  // Results are registered on the edge into DONE so
  // they are valid in the same cycle as done_o.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      remd_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush_i) begin
        state_q <= DIV_IDLE;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          DIV_IDLE: begin
            if (start_i) begin
              if (divisor_i == '0) begin
                quot_q  <= '1;
                remd_q  <= dividend_i;
                done_q  <= 1'b1;
                state_q <= DIV_DONE;
              end else begin
                rem_q   <= '0;
                quo_q   <= dvd_mag;
                dvs_q   <= dvs_mag;
                qneg_q  <= dvd_neg ^ dvs_neg;
                rneg_q  <= dvd_neg;
                cnt_q   <= '0;
                state_q <= DIV_CALC;
              end
            end
          end
          DIV_CALC: begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
            if (last) begin
              quot_q  <= qneg_q ? -quo_d : quo_d;
              remd_q  <= rneg_q ? -rem_d : rem_d;
              done_q  <= 1'b1;
              state_q <= DIV_DONE;
            end
          end
          // start_i here still belongs to the finished op
          DIV_DONE: state_q <= DIV_IDLE;
          default:  state_q <= DIV_IDLE;
        endcase
      end
    end
  end

  assign stall_o = ((state_q == DIV_IDLE) & start_i & ~flush_i)
                 | (state_q == DIV_CALC);

  assign done_o      = done_q;
  assign quotient_o  = quot_q;
  assign remainder_o = remd_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit.
// Drives DIV/DIVU ops, checks results, latency and stall.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start_i = 1'b0;
  logic        signed_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic        stall_o;
  logic        done_o;
  logic [31:0] quotient_o;
  logic [31:0] remainder_o;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] last_q = '0;
  logic [31:0] last_r = '0;

  always #5 clk = ~clk;

  div_unit #(
    .WIDTH(32)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start_i     (start_i),
    .signed_i    (signed_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .flush_i     (flush_i),
    .stall_o     (stall_o),
    .done_o      (done_o),
    .quotient_o  (quotient_o),
    .remainder_o (remainder_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic sgn,
                                 input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t e;
    int   da;
    int   db;
    if (b == 32'd0) begin
      e.q = 32'hFFFF_FFFF;
      e.r = a;
    end else if (!sgn) begin
      e.q = a / b;
      e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = 32'h8000_0000;
      e.r = 32'd0;
    end else begin
      da  = int'(a);
      db  = int'(b);
      e.q = 32'(da / db);
      e.r = 32'(da % db);
    end
    return e;
  endfunction

  task automatic do_div(input string tag,
                        input logic sgn,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int exp_lat);
    int   k;
    int   stalls;
    bit   got;
    exp_t e;
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = a;
    divisor_i  = b;
    sb.push_back(model(sgn, a, b));
    k      = 0;
    stalls = 0;
    got    = 1'b0;
    while (!got && k < 100) begin
      #1;
      if (stall_o) stalls++;
      if (done_o) begin
        got = 1'b1;
      end else begin
        @(negedge clk);
        k++;
      end
    end
    if (!got) begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
      start_i = 1'b0;
      return;
    end
    check({tag, "_lat"}, 32'(k), 32'(exp_lat));
    check({tag, "_stall"}, 32'(stalls), 32'(exp_lat));
    e = sb.pop_front();
    check({tag, "_q"}, quotient_o, e.q);
    check({tag, "_r"}, remainder_o, e.r);
    last_q  = e.q;
    last_r  = e.r;
    start_i = 1'b0;
    @(negedge clk);
    #1;
    check({tag, "_pulse"}, {31'd0, done_o}, 32'd0);
  endtask

  initial begin
    int n_done;
    logic [31:0] ra;
    logic [31:0] rb;

    repeat (2) @(negedge clk);
    #1;
    check("rst_q", quotient_o, 32'd0);
    check("rst_r", remainder_o, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    resetn = 1'b1;

    do_div("u100_7", 1'b0, 32'd100, 32'd7, 33);
    do_div("sneg_dvd", 1'b1, 32'hFFFF_FFF9, 32'd2, 33);
    do_div("sneg_dvs", 1'b1, 32'd7, 32'hFFFF_FFFE, 33);
    do_div("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33);
    do_div("u_max1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33);
    do_div("dz", 1'b1, 32'h1234_5678, 32'd0, 1);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i[0]) rb = rb >> 20;
      if (rb == 32'd0) rb = 32'd3;
      do_div("rand", i[1], ra, rb, 33);
    end

    // flush on CALC cycle 10
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = 1'b0;
    dividend_i = 32'd50;
    divisor_i  = 32'd5;
    repeat (10) @(negedge clk);
    flush_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("fl_idle", {31'd0, stall_o}, 32'd0);
    check("fl_done", {31'd0, done_o}, 32'd0);
    check("fl_hold_q", quotient_o, last_q);
    check("fl_hold_r", remainder_o, last_r);
    n_done = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (done_o) n_done++;
    end
    check("fl_nodone", 32'(n_done), 32'd0);
    check("fl_hold2_q", quotient_o, last_q);
    do_div("u9_3", 1'b0, 32'd9, 32'd3, 33);

    // async reset mid-CALC
    @(negedge clk);
    start_i    = 1'b1;
    signed_i   = 1'b0;
    dividend_i = 32'd100;
    divisor_i  = 32'd7;
    repeat (5) @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_q", quotient_o, 32'd0);
    check("ar_r", remainder_o, 32'd0);
    check("ar_done", {31'd0, done_o}, 32'd0);
    start_i = 1'b0;
    #1;
    check("ar_idle", {31'd0, stall_o}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    do_div("ar_u100_7", 1'b0, 32'd100, 32'd7, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
